// File: rtl/dec_col_locator.sv
// dec_col_locator
//   Sequential H-matrix column search for the Hamming decoder. Takes a
//   syndrome and a codeword-width mode over valid/ready. Each SEARCH cycle
//   compares LANES columns. It returns the lowest matching column index and
//   its class (data/parity), or flags the syndrome as uncorrectable.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           request handshake (in_ready only in IDLE, !rst)
//   s [SYND_W]                  syndrome
//   codeword_width [2]          00 K=8, 01 K=16, 10 K=32, 11 reserved
//   out_valid/out_ready         response handshake, result held until accepted
//   out_status [2]              00 none, 01 data col, 10 parity col, 11 uncorrectable
//   out_col [COL_W]             matching column index (0 unless status 01/10)
//   isCol                       status is 01 or 10
//   stat_corr/stat_uncorr [16]  only with DEC_COL_STATS_EN: saturating counts of
//                               accepted results with status 01/10 and 11
//
// Optional feature macro: DEC_COL_STATS_EN
module dec_col_locator #(
  parameter int SYND_W = 6,
  parameter int LANES  = 4,
  parameter int COL_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SYND_W-1:0] s,
  input  logic [1:0]        codeword_width,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_status,
  output logic [COL_W-1:0]  out_col,
  output logic              isCol
`ifdef DEC_COL_STATS_EN
  ,
  output logic [15:0]       stat_corr,
  output logic [15:0]       stat_uncorr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RESP} state_t;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_DATA  = 2'b01;
  localparam logic [1:0] ST_PAR   = 2'b10;
  localparam logic [1:0] ST_UNCOR = 2'b11;

  // Number of data columns K and total columns n for a mode.
  function automatic int k_of(input logic [1:0] m);
    return 8 << m;
  endfunction

  function automatic int n_of(input logic [1:0] m);
    return k_of(m) + SYND_W - 2 + int'(m);
  endfunction

  // H column value at index idx. Data column d is the d-th integer >= 3 that
  // is not a power of two: start at d+3 and step over each power of two
  // (4, 8, 16, ...) the running value has reached. Parity column K+p is 2^p.
  function automatic logic [SYND_W-1:0] col_val(input int idx, input logic [1:0] m);
    int v;
    if (idx < k_of(m)) begin
      v = idx + 3;
      for (int b = 2; b < SYND_W; b++)
        if (v >= (1 << b)) v = v + 1;
    end else begin
      v = 1 << (idx - k_of(m));
    end
    return v[SYND_W-1:0];
  endfunction

  state_t            r_state;
  logic [SYND_W-1:0] r_s;
  logic [1:0]        r_mode;
  logic [COL_W-1:0]  r_grp;

  int                w_base;
  int                w_n;
  int                w_lane;
  int                w_col;
  int                w_p_in;
  logic [LANES-1:0]  w_hit;
  logic              w_found;
  logic              w_last;
  logic              w_high;

  assign in_ready = (r_state == S_IDLE) && !rst;

  assign w_base = int'(r_grp) * LANES;
  assign w_n    = n_of(r_mode);
  assign w_last = (w_base + LANES) >= w_n;

  // Per-lane column compare for the current group; lanes past n never hit.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_hit[l] = ((w_base + l) < w_n) && (col_val(w_base + l, r_mode) == r_s);
  end

  // Lowest matching lane wins.
  always_comb begin
    w_found = 1'b0;
    w_lane  = 0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_hit[l]) begin
        w_found = 1'b1;
        w_lane  = l;
      end
    end
  end

  assign w_col = w_base + w_lane;

  // Any syndrome bit at or above P cannot name a column of this mode.
  assign w_p_in = SYND_W - 2 + int'(codeword_width);
  assign w_high = (s >> w_p_in) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_s        <= '0;
      r_mode     <= '0;
      r_grp      <= '0;
      out_valid  <= 1'b0;
      out_status <= ST_NONE;
      out_col    <= '0;
      isCol      <= 1'b0;
`ifdef DEC_COL_STATS_EN
      stat_corr   <= '0;
      stat_uncorr <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_s    <= s;
            r_mode <= codeword_width;
            r_grp  <= '0;
            if (s == '0) begin
              r_state    <= S_RESP;
              out_valid  <= 1'b1;
              out_status <= ST_NONE;
            end else if (codeword_width == 2'b11 || w_high) begin
              r_state    <= S_RESP;
              out_valid  <= 1'b1;
              out_status <= ST_UNCOR;
            end else begin
              r_state <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          if (w_found) begin
            r_state    <= S_RESP;
            out_valid  <= 1'b1;
            out_status <= (w_col < k_of(r_mode)) ? ST_DATA : ST_PAR;
            out_col    <= COL_W'(w_col);
            isCol      <= 1'b1;
          end else if (w_last) begin
            r_state    <= S_RESP;
            out_valid  <= 1'b1;
            out_status <= ST_UNCOR;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_state    <= S_IDLE;
            out_valid  <= 1'b0;
            out_status <= ST_NONE;
            out_col    <= '0;
            isCol      <= 1'b0;
`ifdef DEC_COL_STATS_EN
            if (isCol && stat_corr != 16'hFFFF)
              stat_corr <= stat_corr + 16'd1;
            if (out_status == ST_UNCOR && stat_uncorr != 16'hFFFF)
              stat_uncorr <= stat_uncorr + 16'd1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_col_locator.sv
module tb_dec_col_locator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] s = '0;
  logic [1:0] codeword_width = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_status;
  logic [5:0] out_col;
  logic       isCol;
`ifdef DEC_COL_STATS_EN
  logic [15:0] stat_corr, stat_uncorr;
`endif

  dec_col_locator #(.SYND_W(6), .LANES(4), .COL_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .codeword_width(codeword_width),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_status(out_status), .out_col(out_col), .isCol(isCol)
`ifdef DEC_COL_STATS_EN
    , .stat_corr(stat_corr), .stat_uncorr(stat_uncorr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    int         col;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;
  int   hs_corr = 0;
  int   hs_uncorr = 0;
  logic pv = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: each new response (rising out_valid) is checked against the
  // oldest expectation, including the cycle it appeared in.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      hs_corr = 0;
      hs_uncorr = 0;
    end else begin
      if (out_valid && !pv) begin
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_out_valid: got status %0d col %0d, no response expected (cycle %0d)",
                   out_status, out_col, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("status", int'(out_status), int'(e.st));
          chk("col", int'(out_col), e.col);
          chk("isCol", int'(isCol), (e.st == 2'b01 || e.st == 2'b10) ? 1 : 0);
          chk("latency_cycle", cyc, e.cyc);
        end
      end
      if (out_valid && out_ready) begin
        if (out_status == 2'b01 || out_status == 2'b10) hs_corr++;
        if (out_status == 2'b11) hs_uncorr++;
      end
      pv = out_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  // Issue one request and block until its response has been handshaken.
  task automatic send(input logic [5:0] sv, input logic [1:0] mv,
                      input logic [1:0] st, input int col, input int lat);
    int n = 0;
    @(negedge clk);
    wait_ready();
    s = sv;
    codeword_width = mv;
    in_valid = 1'b1;
    sb.push_back('{st, col, cyc + lat});
    @(negedge clk);
    in_valid = 1'b0;
    s = 6'($urandom);
    codeword_width = 2'($urandom);
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("response_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    logic [1:0] hs;
    logic [5:0] hc;
    int n;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_status", int'(out_status), 0);
    chk("rst_col", int'(out_col), 0);
    chk("rst_isCol", int'(isCol), 0);
    rst = 1'b0;

    // Directed vectors: syndrome, mode, status, column, latency
    send(6'b000110, 2'b00, 2'b01, 2, 2);    // data col 2
    send(6'b000100, 2'b00, 2'b10, 10, 4);   // parity col 10
    send(6'b001101, 2'b00, 2'b11, 0, 4);    // no match, n=12, G=2
    send(6'b001011, 2'b01, 2'b01, 6, 3);    // data col 6, group 1
    send(6'b011011, 2'b01, 2'b11, 0, 7);    // n=21, G=5
    send(6'b111001, 2'b10, 2'b11, 0, 11);   // n=38, G=9
    send(6'b010011, 2'b00, 2'b11, 0, 1);    // bit above P
    send(6'b000000, 2'b10, 2'b00, 0, 1);    // zero syndrome
    send(6'b000110, 2'b11, 2'b11, 0, 1);    // reserved mode
    send(6'b000011, 2'b00, 2'b01, 0, 2);    // first column
    send(6'b000001, 2'b10, 2'b10, 32, 10);  // first parity col, mode 2
    send(6'b100110, 2'b10, 2'b01, 31, 9);   // last data col, mode 2
    send(6'b010000, 2'b01, 2'b10, 20, 7);   // last column, mode 1
    send(6'b100000, 2'b01, 2'b11, 0, 1);    // bit 5 set with P=5
    send(6'b111111, 2'b10, 2'b11, 0, 11);   // full-width miss, mode 2

    // Backpressure: result must hold while out_ready is low
    @(negedge clk);
    wait_ready();
    out_ready = 1'b0;
    s = 6'b000110;
    codeword_width = 2'b00;
    in_valid = 1'b1;
    sb.push_back('{2'b01, 2, cyc + 2});
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", int'(out_valid), 1);
    hs = out_status;
    hc = out_col;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_status", int'(out_status), int'(2'b01));
      chk("hold_col", int'(out_col), 2);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_valid", int'(out_valid), 0);
    chk("post_hs_in_ready", int'(in_ready), 1);

    // Reset in the middle of a search: no response may appear
    wait_ready();
    s = 6'b001101;
    codeword_width = 2'b00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_ready", int'(in_ready), 0);
    chk("rst_mid_valid", int'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready", int'(in_ready), 1);
    repeat (6) @(negedge clk);
    chk("rst_mid_no_valid", int'(out_valid), 0);

    // Reset together with in_valid: nothing accepted
    s = 6'b000110;
    codeword_width = 2'b00;
    in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_accept_no_valid", int'(out_valid), 0);

    // Traffic after the resets
    send(6'b000101, 2'b00, 2'b01, 1, 2);
    send(6'b001110, 2'b00, 2'b11, 0, 4);
    send(6'b001000, 2'b00, 2'b10, 11, 4);

`ifdef DEC_COL_STATS_EN
    @(negedge clk);
    chk("stat_corr", int'(stat_corr), hs_corr);
    chk("stat_uncorr", int'(stat_uncorr), hs_uncorr);
    chk("stat_corr_abs", int'(stat_corr), 2);
    chk("stat_uncorr_abs", int'(stat_uncorr), 1);
`endif

    if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
